// File: rtl/timer_pkg.sv
// Shared types and helpers for the cascaded up/down digit timer.
package timer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLAMP_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } timer_state_e;

  // Saturate a preset digit so the counter never holds an out-of-range value.
  function automatic logic [CLAMP_W-1:0] clamp_digit(input logic [CLAMP_W-1:0] d,
                                                     input logic [CLAMP_W-1:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/timer_digit.sv
// One modulo-(DIGIT_MAX+1) up/down digit with load and clear; boundary flags are combinational.
module timer_digit #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned DIGIT_MAX = 9
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               step,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               clear,
  output logic [DIGIT_W-1:0] value,
  output logic               at_max_c,
  output logic               at_zero_c
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(DIGIT_MAX);

  assign at_max_c  = (value == MAX_V);
  assign at_zero_c = (value == '0);

  // Clear dominates load, load dominates stepping.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      if (dir) value <= at_max_c  ? '0    : value + DIGIT_W'(1);
      else     value <= at_zero_c ? MAX_V : value - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/timer_cascade.sv
// Chain of DIGITS up/down digits under a run/pause/stop/done control FSM with carry and done flags.
module timer_cascade
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned DIGIT_MAX = 9
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      set_time,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      UpOrDown,
  input  logic                      one_shot,
  input  logic                      tick_en,
  input  logic [DIGITS*DIGIT_W-1:0] Init_value,
  output logic [DIGITS*DIGIT_W-1:0] Count,
  output logic                      carry,
  output logic                      done,
  output logic                      running
);

  timer_state_e state_q, state_d;

  logic [DIGIT_W-1:0] digit_val [DIGITS];
  logic [DIGITS-1:0]  at_max, at_zero, bnd, lower_bnd;
  logic               all_bnd;
  logic               step_en, wrap, load, clear;

  // Boundary of each digit depends on the current direction.
  assign bnd = UpOrDown ? at_max : at_zero;

  // Ripple enable: digit i may step only when every lower digit sits at its boundary.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    lower_bnd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lower_bnd[i] = acc;
      acc          = acc & bnd[i];
    end
    all_bnd = acc;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    wrap    = 1'b0;
    if (set_time) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stop)                state_d = ST_STOP;
          else if (start && !pause) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop)                  state_d = ST_STOP;
          else if (pause || !start)  state_d = ST_PAUSE;
          else if (tick_en) begin
            if (all_bnd && one_shot) begin
              state_d = ST_DONE;
            end else begin
              step_en = 1'b1;
              wrap    = all_bnd;
            end
          end
        end
        ST_PAUSE: begin
          if (stop)                 state_d = ST_STOP;
          else if (start && !pause) state_d = ST_RUN;
        end
        ST_STOP: state_d = ST_STOP;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Preset is reloaded throughout IDLE and on set_time; STOP forces the count to zero.
  assign clear = (state_d == ST_STOP);
  assign load  = set_time || (state_q == ST_IDLE);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      carry   <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      carry   <= wrap;
      done    <= (state_d == ST_DONE);
      running <= (state_d == ST_RUN);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] preset;
    assign preset = DIGIT_W'(clamp_digit(CLAMP_W'(Init_value[i*DIGIT_W +: DIGIT_W]),
                                         CLAMP_W'(DIGIT_MAX)));

    timer_digit #(
      .DIGIT_W  (DIGIT_W),
      .DIGIT_MAX(DIGIT_MAX)
    ) u_digit (
      .Clk      (Clk),
      .reset    (reset),
      .step     (step_en && lower_bnd[i]),
      .dir      (UpOrDown),
      .load     (load),
      .load_val (preset),
      .clear    (clear),
      .value    (digit_val[i]),
      .at_max_c (at_max[i]),
      .at_zero_c(at_zero[i])
    );

    assign Count[i*DIGIT_W +: DIGIT_W] = digit_val[i];
  end

endmodule
